// File: rtl/vga_sync_receiver.sv
// Recovers VGA line/frame timing from hSync/vSync pixel-tick samples, locks after
// LOCK_FRAMES clean frames and emits visible-window pixels with their coordinates.
module vga_sync_receiver #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       hSync,
    input  logic       vSync,
    input  logic [7:0] rgb,
    output logic [9:0] hPos,
    output logic [9:0] vPos,
    output logic [7:0] pixel,
    output logic       pixelValid,
    output logic       locked,
    output logic       frameDone,
    output logic       syncError,
    output logic [7:0] frameCount,
    output logic [1:0] dbgState
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] CNT_MAX     = 10'h3FF;
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] V_TOTAL_C   = 10'(V_TOTAL);
    localparam logic [9:0] H_WIN_LO    = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_WIN_HI    = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [9:0] V_WIN_LO    = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_WIN_HI    = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam logic [7:0] LOCK_C      = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       hs_prev_q, vs_prev_q;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d, v_cnt_inc;
    logic       first_h_q, first_h_d;
    logic [7:0] good_q, good_d, good_inc;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_done_q, frame_done_d;
    logic       sync_err_q, sync_err_d;
    logic       pix_valid_q, pix_valid_d;
    logic [9:0] h_pos_q, h_pos_d;
    logic [9:0] v_pos_q, v_pos_d;
    logic [7:0] pixel_q, pixel_d;

    logic       hs_fall, hs_rise, vs_fall;
    logic       h_len_err, h_pulse_err, h_timeout, v_frame_err, any_err;
    logic       in_window;

    // Edge detection and the free-running line/frame counters.
    always_comb begin
        hs_fall = enable & hs_prev_q & ~hSync;
        hs_rise = enable & ~hs_prev_q & hSync;
        vs_fall = enable & vs_prev_q & ~vSync;

        h_cnt_d = h_cnt_q;
        if (hs_fall) begin
            h_cnt_d = '0;
        end else if (h_cnt_q != CNT_MAX) begin
            h_cnt_d = h_cnt_q + 10'd1;
        end

        // A coincident hSync edge is counted before the vSync check sees vCnt.
        v_cnt_inc = v_cnt_q;
        if (hs_fall && (v_cnt_q != CNT_MAX)) begin
            v_cnt_inc = v_cnt_q + 10'd1;
        end
        v_cnt_d = vs_fall ? '0 : v_cnt_inc;
    end

    always_comb begin
        h_len_err   = hs_fall & ~first_h_q & (h_cnt_q != H_LAST);
        h_pulse_err = hs_rise & (h_cnt_q != H_SYNC_LAST);
        h_timeout   = enable & ~hs_fall & (h_cnt_q == H_LAST);
        v_frame_err = vs_fall & (v_cnt_inc != V_TOTAL_C);
        any_err     = h_len_err | h_pulse_err | h_timeout | v_frame_err;
    end

    always_comb begin
        state_d      = state_q;
        first_h_d    = first_h_q;
        good_inc     = good_q + 8'd1;
        good_d       = good_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (hs_fall) begin
            first_h_d = 1'b0;
        end

        case (state_q)
            SEARCH: begin
                // Counts here are of unknown phase, so nothing is judged yet.
                if (vs_fall) begin
                    state_d   = ACQUIRE;
                    good_d    = '0;
                    first_h_d = 1'b1;
                end
            end
            ACQUIRE: begin
                if (any_err) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end else if (vs_fall) begin
                    good_d = good_inc;
                    if (good_inc >= LOCK_C) begin
                        state_d     = LOCKED;
                        frame_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end else if (vs_fall) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // pixelValid is a one-clk strobe qualifying hPos/vPos/pixel; there is no
    // back-pressure, so a consumer must capture the sample on that clk.
    always_comb begin
        in_window = (h_cnt_d >= H_WIN_LO) && (h_cnt_d <= H_WIN_HI) &&
                    (v_cnt_d >= V_WIN_LO) && (v_cnt_d <= V_WIN_HI);
        pix_valid_d = enable & in_window & (state_d == LOCKED);
        h_pos_d     = h_pos_q;
        v_pos_d     = v_pos_q;
        pixel_d     = pixel_q;
        if (pix_valid_d) begin
            h_pos_d = h_cnt_d - H_WIN_LO;
            v_pos_d = v_cnt_d - V_WIN_LO;
            pixel_d = rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            first_h_q    <= 1'b0;
            good_q       <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            h_pos_q      <= '0;
            v_pos_q      <= '0;
            pixel_q      <= '0;
        end else begin
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            pix_valid_q  <= pix_valid_d;
            if (enable) begin
                state_q     <= state_d;
                hs_prev_q   <= hSync;
                vs_prev_q   <= vSync;
                h_cnt_q     <= h_cnt_d;
                v_cnt_q     <= v_cnt_d;
                first_h_q   <= first_h_d;
                good_q      <= good_d;
                frame_cnt_q <= frame_cnt_d;
                h_pos_q     <= h_pos_d;
                v_pos_q     <= v_pos_d;
                pixel_q     <= pixel_d;
            end
        end
    end

    assign hPos       = h_pos_q;
    assign vPos       = v_pos_q;
    assign pixel      = pixel_q;
    assign pixelValid = pix_valid_q;
    assign locked     = (state_q == LOCKED);
    assign frameDone  = frame_done_q;
    assign syncError  = sync_err_q;
    assign frameCount = frame_cnt_q;
    assign dbgState   = state_q;

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, H_SYNC, 96, H_BACK, 48: horizontal porch/sync lengths in pixel ticks (H_TOTAL = 800).
REQ-003 Parameter V_VISIBLE, 480, V_FRONT, 10, V_SYNC, 2, V_BACK, 33: vertical lengths in lines (V_TOTAL = 525).
REQ-004 Parameter LOCK_FRAMES, 2, consecutive error-free frames required to lock.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  pixel-tick strobe (25 MHz pulse); inputs are sampled only when high.
REQ-008 hSync  input  1  horizontal sync, active low.
REQ-009 vSync  input  1  vertical sync, active low.
REQ-010 rgb  input  8  pixel colour.
REQ-011 hPos  output  10  recovered column of pixel, 0..639.
REQ-012 vPos  output  10  recovered row of pixel, 0..479.
REQ-013 pixel  output  8  registered rgb of that position.
REQ-014 pixelValid  output  1  high for one enable tick when locked and the sample is inside the visible window.
REQ-015 locked  output  1  high in state LOCKED.
REQ-016 frameDone  output  1  one-clk pulse at end of each good frame while LOCKED.
REQ-017 syncError  output  1  one-clk pulse on any timing violation.
REQ-018 frameCount  output  8  good frames since lock, wrapping 255->0.

Function
REQ-019 All state, counters and registered outputs SHALL update only on clk edges with enable=1; with enable=0 they hold and frameDone/syncError/pixelValid are 0.
REQ-020 Assertion edge = sampled sync 1 previous tick, 0 this tick; deassertion edge = 0 then 1.
REQ-021 hCnt (10 bit) SHALL reset to 0 on hSync assertion edge, else increment, saturating at 1023.
REQ-022 On hSync assertion edge the previous line length hCnt+1 SHALL equal H_TOTAL, except for the first edge after entering ACQUIRE; mismatch = error.
REQ-023 On hSync deassertion edge hCnt SHALL equal H_SYNC-1, else error.
REQ-024 hCnt reaching H_TOTAL with no assertion edge = error (timeout).
REQ-025 vCnt (10 bit) SHALL increment on each hSync assertion edge and reset to 0 on vSync assertion edge.
REQ-026 On vSync assertion edge vCnt SHALL equal V_TOTAL (frame count check) unless this is the first vSync edge after SEARCH; mismatch = error.
REQ-027 Simultaneous hSync and vSync assertion edges: hSync checks and increment first, then vSync check on the incremented vCnt, then vCnt := 0.
REQ-028 FSM states SEARCH, ACQUIRE, LOCKED; reset state SEARCH.
REQ-029 SEARCH -> ACQUIRE on first vSync assertion edge; good-frame counter := 0; errors are not flagged in SEARCH.
REQ-030 ACQUIRE: each error-free vSync check increments good-frame counter; reaching LOCK_FRAMES -> LOCKED, frameCount := 0.
REQ-031 ACQUIRE or LOCKED: any error -> SEARCH with syncError pulsed the same clk; locked drops the same clk.
REQ-032 LOCKED: each error-free vSync check pulses frameDone and increments frameCount.
REQ-033 Visible window: hCnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] and vCnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1].
REQ-034 hPos = hCnt-(H_SYNC+H_BACK), vPos = vCnt-(V_SYNC+V_BACK), pixel = rgb, all registered; latency one enable tick from sample to pixelValid.
REQ-035 Outside the window or not LOCKED, pixelValid = 0 and hPos/vPos/pixel hold their last values.

Reset
REQ-036 reset=1 SHALL, at the next clk edge regardless of enable: state SEARCH, hCnt=vCnt=0, hPos=vPos=0, pixel=0, pixelValid=locked=frameDone=syncError=0, frameCount=0, sync history registers = 1 (deasserted).
REQ-037 Reset asserted mid-frame SHALL abandon lock; relocking requires a new vSync edge plus LOCK_FRAMES good frames.

Verification
REQ-038 Standard 640x480 stream from the team's VGA generator, enable every 4th clk -> locked rises at the vSync edge that ends the second complete frame; frameDone then pulses once per frame and frameCount increments 0,1,2...
REQ-039 Locked, drive rgb = hPos[7:0] pattern -> first pixelValid tick reports hPos=0, vPos=0, pixel=0x00; last reports hPos=639, vPos=479, pixel=0x7F; exactly 307200 pixelValid ticks per frame.
REQ-040 Locked, shorten one line to 799 ticks -> syncError one clk at that hSync edge, locked=0 same clk, pixelValid=0 until relock.
REQ-041 Locked, stretch one hSync pulse to 97 ticks -> syncError at deassertion edge, state SEARCH.
REQ-042 Locked, hold hSync high for 900 ticks -> syncError when hCnt reaches 800; no frameDone that frame.
REQ-043 reset pulsed mid-frame while locked, enable=0 -> all outputs at REQ-036 values next clk; relock after 2 further good frames.
